// File: rtl/regfile_dump_reader.sv
// Streams a contiguous, wrapping range of register-file words out over valid/ready,
// holding the core's RegWrite off (rf_hold) for the whole dump so the snapshot stays coherent.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              rf_hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Output handshake: a word transfers on a rising edge where out_valid && out_ready;
  // once raised, out_valid and its payload stay stable until that transfer.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   end_addr_q, end_addr_d;
  logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
  logic                rf_hold_q, rf_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic                out_last_q, out_last_d;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    end_addr_d  = end_addr_q;
    rf_addr_d   = rf_addr_q;
    rf_hold_d   = rf_hold_q;
    busy_d      = busy_q;
    done_d      = done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d      = first_addr;
          end_addr_d = last_addr;
          rf_addr_d  = first_addr;
          rf_hold_d  = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_SETTLE;
        end
      end
      // One idle cycle so the core's gated RegWrite is in force before the first read.
      S_SETTLE: begin
        rf_addr_d = cur_q;
        state_d   = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d  = rf_data;
        out_addr_d  = cur_q;
        out_last_d  = (cur_q == end_addr_q);
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cur_q != end_addr_q) begin
            cur_d     = cur_q + ADDR_W'(1);
            rf_addr_d = cur_q + ADDR_W'(1);
            state_d   = S_CAPTURE;
          end else begin
            out_last_d = 1'b0;
            done_d     = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d    = 1'b0;
        rf_hold_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      end_addr_q  <= '0;
      rf_addr_q   <= '0;
      rf_hold_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      end_addr_q  <= end_addr_d;
      rf_addr_q   <= rf_addr_d;
      rf_hold_q   <= rf_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign rf_hold   = rf_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign dbg_state = state_q;

endmodule
